seg7_scan_driver: RTL and testbench

Four-digit multiplexed seven-segment display driver that consumes count values produced by the board's counter stages and shows them in hexadecimal on a common-anode display. It sits directly downstream of the counters: counter outputs feed `value`. The block scans one digit at a time from a programmable refresh prescaler. It double-buffers the input so the displayed value only changes at frame boundaries.

---
 rtl/seg7_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed hex display driver with a frame-aligned display buffer.
// The scan is paced by a programmable prescaler, and leading zeros can be blanked.
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_value,
    input  logic        i_load,
    input  logic        i_blank_lz,
    input  logic [3:0]  i_dp,
    output logic [6:0]  o_seg,
    output logic        o_dp_out,
    output logic [3:0]  o_an,
    output logic        o_frame
);

    localparam int            PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PTERM = PW'(SCAN_DIV - 1);
    localparam logic          POL   = (ACTIVE_LOW != 0);

    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [15:0]   r_disp;
    logic [3:0]    r_lz;
    logic          r_frame;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;

    logic          w_term;
    logic          w_boundary;
    logic [15:0]   w_next_disp;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg_ah;
    logic [3:0]    w_an_ah;
    logic          w_dp_ah;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Bit k set when digits k..3 are all zero; digit 0 always stays lit.
    function automatic logic [3:0] lz_flags(input logic [15:0] v);
        logic [3:0] f;
        f[3] = (v[15:12] == 4'h0);
        f[2] = f[3] && (v[11:8] == 4'h0);
        f[1] = f[2] && (v[7:4] == 4'h0);
        f[0] = 1'b0;
        return f;
    endfunction

    assign w_term      = (r_pcnt == PTERM);
    assign w_boundary  = w_term && (r_idx == 2'd3);
    assign w_next_disp = i_load ? i_value : r_shadow;
    assign w_nib       = r_disp[r_idx*4 +: 4];
    assign w_seg_ah    = (i_blank_lz && r_lz[r_idx]) ? 7'h00 : hex7(w_nib);
    assign w_an_ah     = 4'b0001 << r_idx;
    assign w_dp_ah     = i_dp[r_idx];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pcnt   <= '0;
            r_idx    <= 2'd0;
            r_shadow <= 16'h0000;
            r_disp   <= 16'h0000;
            r_lz     <= lz_flags(16'h0000);
            r_frame  <= 1'b0;
            r_seg    <= {7{POL}};
            r_dp     <= POL;
            r_an     <= {4{POL}};
        end else begin
            if (w_term) begin
                r_pcnt <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_pcnt <= r_pcnt + PW'(1);
            end
            if (i_load) begin
                r_shadow <= i_value;
            end
            // A load on the boundary cycle goes straight to the display buffer.
            if (w_boundary) begin
                r_disp <= w_next_disp;
                r_lz   <= lz_flags(w_next_disp);
            end
            r_frame <= w_boundary;
            r_seg   <= w_seg_ah ^ {7{POL}};
            r_dp    <= w_dp_ah ^ POL;
            r_an    <= w_an_ah ^ {4{POL}};
        end
    end

    assign o_seg    = r_seg;
    assign o_dp_out = r_dp;
    assign o_an     = r_an;
    assign o_frame  = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-count based reference model plus directed
// literal checks for reset, scan order, blanking, double buffering and dp.
module tb_seg7_scan_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp = 4'h0;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_driver #(.SCAN_DIV(SD), .ACTIVE_LOW(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load),
        .i_blank_lz(blank_lz), .i_dp(dp),
        .o_seg(seg), .o_dp_out(dp_out), .o_an(an), .o_frame(frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_ah(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[d];
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: everything follows from the number of edges since reset.
    int          t = 0;
    int          dg;
    bit          m_valid = 1'b0;
    bit          blank;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_disp = 16'h0000;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_frame;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (!rst) begin
            t = 0;
            m_shadow = 16'h0000;
            m_disp = 16'h0000;
            e_an = 4'hF;
            e_seg = 7'h7F;
            e_dp = 1'b1;
            e_frame = 1'b0;
        end else begin
            dg = (t / SD) % 4;
            e_an = ~(4'b0001 << dg);
            blank = blank_lz && (dg > 0) && ((m_disp >> (4 * dg)) == 16'h0000);
            e_seg = blank ? 7'h7F : ~hex_ah(4'((m_disp >> (4 * dg)) & 16'h000F));
            e_dp = ~dp[dg];
            e_frame = ((t % SD) == SD - 1) && (dg == 3);
            if (e_frame) m_disp = load ? value : m_shadow;
            if (load) m_shadow = value;
            t++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_an", 16'(an), 16'(e_an));
            check("model_seg", 16'(seg), 16'(e_seg));
            check("model_dp", 16'(dp_out), 16'(e_dp));
            check("model_frame", 16'(frame), 16'(e_frame));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        bit got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("frame_timeout", 16'(got), 16'h1);
    endtask

    task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es);
        check({name, "_an"}, 16'(an), 16'(ea));
        check({name, "_seg"}, 16'(seg), 16'(es));
    endtask

    initial begin
        // Reset held for three cycles.
        step(3);
        lit("rst", 4'hF, 7'h7F);
        check("rst_dp", 16'(dp_out), 16'h1);
        check("rst_frame", 16'(frame), 16'h0);
        rst = 1'b1;
        step(1);
        lit("first", 4'hE, 7'h40);

        // Scan order.
        pulse_load(16'h1234);
        wait_frame();
        step(1); lit("scan0", 4'hE, 7'h19);
        step(4); lit("scan1", 4'hD, 7'h30);
        step(4); lit("scan2", 4'hB, 7'h24);
        step(4); lit("scan3", 4'h7, 7'h79);

        // Leading-zero blanking with a dp on a blanked digit.
        blank_lz = 1'b1;
        dp = 4'b0100;
        pulse_load(16'h0050);
        wait_frame();
        step(1); lit("lz0", 4'hE, 7'h40); check("dp0", 16'(dp_out), 16'h1);
        step(4); lit("lz1", 4'hD, 7'h12); check("dp1", 16'(dp_out), 16'h1);
        step(4); lit("lz2", 4'hB, 7'h7F); check("dp2", 16'(dp_out), 16'h0);
        step(4); lit("lz3", 4'h7, 7'h7F); check("dp3", 16'(dp_out), 16'h1);
        dp = 4'h0;
        pulse_load(16'h0000);
        wait_frame();
        step(1); lit("z0", 4'hE, 7'h40);
        step(4); lit("z1", 4'hD, 7'h7F);
        step(4); lit("z2", 4'hB, 7'h7F);
        step(4); lit("z3", 4'h7, 7'h7F);

        // Double buffering: mid-frame load waits for the next boundary.
        blank_lz = 1'b0;
        pulse_load(16'hAAAA);
        wait_frame();
        step(1); lit("db0", 4'hE, 7'h08);
        step(4); lit("db1", 4'hD, 7'h08);
        pulse_load(16'hBBBB);
        step(3); lit("db2", 4'hB, 7'h08);
        step(4); lit("db3", 4'h7, 7'h08);
        wait_frame();
        step(1); lit("dbn", 4'hE, 7'h03);

        // Load on the boundary cycle itself.
        wait_frame();
        step(15);
        value = 16'hCCCC;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        value = 16'h0000;
        check("coinc_frame", 16'(frame), 16'h1);
        step(1); lit("coinc", 4'hE, 7'h46);

        // Reset during digit 2 with 0xFFFF still pending.
        pulse_load(16'hFFFF);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                if (an === 4'hB) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("reach_d2", 16'(seen), 16'h1);
        end
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1); lit("mr0", 4'hE, 7'h40);
        step(4); lit("mr1", 4'hD, 7'h40);
        step(4); lit("mr2", 4'hB, 7'h40);
        step(4); lit("mr3", 4'h7, 7'h40);
        wait_frame();
        step(1); lit("mrn", 4'hE, 7'h40);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            load = ($urandom_range(0, 5) == 0);
            blank_lz = 1'($urandom_range(0, 1));
            dp = 4'($urandom);
            rst = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        rst = 1'b1;
        load = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
